pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 93 +++++++++
 tb/tb_pc_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC generator with prioritized redirects, halt control and misaligned-target trapping
module pc_sequencer #(
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] START_ADDR = 64'h80000000,
    parameter int                INST_BYTES = 4,
    parameter int                NUM_REDIR  = 4,
    parameter int                EPOCH_W    = 3,
    parameter int                CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REDIR-1:0]        redir_valid,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr,
    input  logic                        halt_req,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [EPOCH_W-1:0]          epoch,
    output logic                        misalign,
    output logic [ADDR_W-1:0]           bad_addr,
    output logic [CNT_W-1:0]            fetch_cnt
);
    typedef enum logic [1:0] {BOOT, RUN, HALT, ERR} state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);

    state_t              r_state;
    state_t              w_next;
    logic                r_valid;
    logic                r_mis;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_bad;
    logic [EPOCH_W-1:0]  r_epoch;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   w_target;
    logic                w_sel;
    logic                w_taken;
    logic                w_mis;
    logic                w_hs;

    // lowest-index requesting source wins, so scan from the top and let lower indices overwrite
    always_comb begin
        w_target = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--)
            if (redir_valid[i]) w_target = redir_addr[i*ADDR_W +: ADDR_W];
    end

    assign w_sel   = |redir_valid && r_state != BOOT;
    assign w_taken = w_sel && (w_target & ALIGN_MASK) == '0;
    assign w_mis   = w_sel && !w_taken;
    assign w_hs    = r_valid && out_ready;

    // next state; a misaligned target traps from any post-boot state
    always_comb begin
        w_next = r_state;
        case (r_state)
            BOOT:    w_next = halt_req ? HALT : RUN;
            RUN:     w_next = w_mis ? ERR : (halt_req && (w_hs || w_taken)) ? HALT : RUN;
            HALT:    w_next = w_mis ? ERR : halt_req ? HALT : RUN;
            ERR:     w_next = w_taken ? (halt_req ? HALT : RUN) : ERR;
            default: w_next = BOOT;
        endcase
    end

    // state and registered outputs; a taken redirect beats the sequential step but a coincident handshake still counts
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
            r_valid <= 1'b0;
            r_pc    <= START_ADDR;
            r_epoch <= '0;
            r_mis   <= 1'b0;
            r_bad   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= w_next == RUN;
            r_pc    <= w_taken ? w_target : w_hs ? r_pc + PC_INC : r_pc;
            r_epoch <= r_epoch + EPOCH_W'(w_taken);
            r_mis   <= w_mis;
            r_bad   <= w_mis ? w_target : r_bad;
            r_cnt   <= r_cnt + CNT_W'(w_hs);
        end
    end

    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign epoch     = r_epoch;
    assign misalign  = r_mis;
    assign bad_addr  = r_bad;
    assign fetch_cnt = r_cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run against a cycle-level behavioural model
module tb_pc_sequencer;
    localparam int          AW    = 64;
    localparam int          NR    = 4;
    localparam int          EW    = 3;
    localparam int          CW    = 32;
    localparam logic [63:0] START = 64'h80000000;
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_ERR = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             halt_req = 1'b0;
    logic             out_ready = 1'b0;
    logic [NR-1:0]    redir_valid = '0;
    logic [NR*AW-1:0] redir_addr = '0;
    logic             out_valid;
    logic             misalign;
    logic [AW-1:0]    out_pc;
    logic [AW-1:0]    bad_addr;
    logic [EW-1:0]    epoch;
    logic [CW-1:0]    fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_mode;
    logic        m_valid, m_mis;
    logic [63:0] m_pc, m_bad;
    logic [2:0]  m_ep;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .redir_valid(redir_valid), .redir_addr(redir_addr),
        .halt_req(halt_req), .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
        .epoch(epoch), .misalign(misalign), .bad_addr(bad_addr), .fetch_cnt(fetch_cnt)
    );

    // advance one clock, updating the reference model from the inputs seen at that edge
    task automatic tick();
        int          sel, nm;
        logic [63:0] tgt;
        bit          hs, req, taken, bad;
        sel = -1;
        for (int i = 0; i < NR && sel < 0; i++) if (redir_valid[i]) sel = i;
        tgt   = sel >= 0 ? redir_addr[sel*AW +: AW] : 64'd0;
        hs    = m_valid && out_ready;
        req   = sel >= 0 && m_mode != M_BOOT;
        taken = req && (tgt % 4 == 0);
        bad   = req && !taken;
        if (m_mode == M_BOOT)      nm = halt_req ? M_HALT : M_RUN;
        else if (bad)              nm = M_ERR;
        else if (m_mode == M_ERR)  nm = taken ? (halt_req ? M_HALT : M_RUN) : M_ERR;
        else if (m_mode == M_HALT) nm = halt_req ? M_HALT : M_RUN;
        else                       nm = (halt_req && (hs || taken)) ? M_HALT : M_RUN;
        @(posedge clk);
        #1;
        if (reset) begin
            m_mode = M_BOOT; m_valid = 0; m_pc = START; m_ep = 0; m_mis = 0; m_bad = 0; m_cnt = 0;
        end else begin
            if (hs) m_cnt = m_cnt + 1;
            if (taken) begin
                m_pc = tgt;
                m_ep = m_ep + 1;
            end else if (hs) m_pc = m_pc + 4;
            m_mis = bad;
            if (bad) m_bad = tgt;
            m_mode  = nm;
            m_valid = nm == M_RUN;
        end
    endtask

    task automatic set_redir(input int i, input logic [63:0] a);
        redir_valid[i] = 1'b1;
        redir_addr[i*AW +: AW] = a;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_redir(0, 64'h80009000);
        out_ready = 1'b1;
        tick();
        tick();
        redir_valid = '0;
        n_tests++;
        if ({out_valid, out_pc, epoch, misalign, bad_addr, fetch_cnt} !== {1'b0, START, 3'd0, 1'b0, 64'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b pc=%h epoch=%0d mis=%0b bad=%h cnt=%0d, required 0 %h 0 0 0 0",
                     out_valid, out_pc, epoch, misalign, bad_addr, fetch_cnt, START);
        end
    endtask

    task automatic test_sequential();
        reset = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_valid: got %0b, required 0", out_valid);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== START + 64'(4 * k)) begin
                n_fail++;
                $display("FAIL seq_pc%0d: valid=%0b pc=%h, required 1 %h", k, out_valid, out_pc, START + 64'(4 * k));
            end
            tick();
        end
        n_tests++;
        if (fetch_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL seq_cnt: got %0d, required 4", fetch_cnt);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 64'h80000010 || fetch_cnt !== 32'd4) begin
                n_fail++;
                $display("FAIL stall_hold: valid=%0b pc=%h cnt=%0d, required 1 80000010 4", out_valid, out_pc, fetch_cnt);
            end
        end
    endtask

    task automatic test_priority();
        out_ready = 1'b1;
        set_redir(1, 64'h80001000);
        set_redir(2, 64'h80002000);
        redir_addr[0 +: AW] = 64'h80000103;
        redir_addr[3*AW +: AW] = 64'h80003000;
        tick();
        redir_valid = '0;
        out_ready = 1'b0;
        n_tests++;
        if (out_pc !== 64'h80001000 || epoch !== 3'd1 || fetch_cnt !== 32'd5 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_priority: pc=%h epoch=%0d cnt=%0d valid=%0b, required 80001000 1 5 1",
                     out_pc, epoch, fetch_cnt, out_valid);
        end
    endtask

    task automatic test_misalign();
        set_redir(0, 64'h80000102);
        tick();
        redir_valid = '0;
        n_tests++;
        if (misalign !== 1'b1 || bad_addr !== 64'h80000102 || out_valid !== 1'b0 || out_pc !== 64'h80001000 || epoch !== 3'd1) begin
            n_fail++;
            $display("FAIL misalign_pulse: mis=%0b bad=%h valid=%0b pc=%h epoch=%0d, required 1 80000102 0 80001000 1",
                     misalign, bad_addr, out_valid, out_pc, epoch);
        end
        tick();
        n_tests++;
        if (misalign !== 1'b0 || out_valid !== 1'b0 || bad_addr !== 64'h80000102) begin
            n_fail++;
            $display("FAIL err_hold: mis=%0b valid=%0b bad=%h, required 0 0 80000102", misalign, out_valid, bad_addr);
        end
        set_redir(0, 64'h80000200);
        tick();
        redir_valid = '0;
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 64'h80000200 || epoch !== 3'd2) begin
            n_fail++;
            $display("FAIL err_recover: valid=%0b pc=%h epoch=%0d, required 1 80000200 2", out_valid, out_pc, epoch);
        end
    endtask

    task automatic test_halt();
        set_redir(3, 64'h80000020);
        tick();
        redir_valid = '0;
        out_ready = 1'b1;
        halt_req = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || out_pc !== 64'h80000024 || fetch_cnt !== 32'd6) begin
            n_fail++;
            $display("FAIL halt_enter: valid=%0b pc=%h cnt=%0d, required 0 80000024 6", out_valid, out_pc, fetch_cnt);
        end
        halt_req = 1'b0;
        out_ready = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 64'h80000024) begin
            n_fail++;
            $display("FAIL halt_exit: valid=%0b pc=%h, required 1 80000024", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap_and_reset();
        set_redir(2, 64'hFFFFFFFFFFFFFFFC);
        tick();
        redir_valid = '0;
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_pc !== 64'd0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pc_wrap: pc=%h valid=%0b, required 0 1", out_pc, out_valid);
        end
        set_redir(0, 64'h80003000);
        reset = 1'b1;
        tick();
        n_tests++;
        if (out_pc !== START || epoch !== 3'd0 || out_valid !== 1'b0 || fetch_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_over_redir: pc=%h epoch=%0d valid=%0b cnt=%0d, required %h 0 0 0",
                     out_pc, epoch, out_valid, fetch_cnt, START);
        end
        reset = 1'b0;
        out_ready = 1'b0;
        set_redir(0, 64'h80004000);
        tick();
        redir_valid = '0;
        n_tests++;
        if (out_pc !== START || epoch !== 3'd0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL boot_ignores_redir: pc=%h epoch=%0d valid=%0b, required %h 0 1", out_pc, epoch, out_valid, START);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset     = $urandom_range(0, 79) == 0;
            halt_req  = $urandom_range(0, 9) == 0;
            out_ready = $urandom_range(0, 2) != 0;
            redir_valid = '0;
            if ($urandom_range(0, 4) == 0) begin
                redir_valid = NR'($urandom_range(1, 15));
                for (int i = 0; i < NR; i++) begin
                    logic [63:0] a;
                    a = $urandom_range(0, 15) == 0 ? 64'hFFFFFFFFFFFFFFF0 + 64'($urandom_range(0, 3) * 4)
                                                   : START + 64'($urandom_range(0, 1023) * 4);
                    if ($urandom_range(0, 5) == 0) a = a + 64'($urandom_range(1, 3));
                    redir_addr[i*AW +: AW] = a;
                end
            end
            tick();
            n_tests++;
            if ({out_valid, out_pc, epoch, misalign, bad_addr, fetch_cnt} !== {m_valid, m_pc, m_ep, m_mis, m_bad, m_cnt}) begin
                n_fail++;
                $display("FAIL random_c%0d: got valid=%0b pc=%h ep=%0d mis=%0b bad=%h cnt=%0d, required %0b %h %0d %0b %h %0d",
                         c, out_valid, out_pc, epoch, misalign, bad_addr, fetch_cnt, m_valid, m_pc, m_ep, m_mis, m_bad, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_priority();
        test_misalign();
        test_halt();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
